// File: rtl/cfr_pkg.sv
// Shared types and helpers for the CFR peak detector.
package cfr_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RISE  = 2'd1,
        S_BLANK = 2'd2
    } pd_state_t;

    function automatic int lane_w(input int lanes);
        return (lanes <= 1) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/cfr_pd_max_tree.sv
// Per-group lane maximum with lowest-index tie-break; result registered on en.
module cfr_pd_max_tree
    import cfr_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DW    = 17,
    parameter int TW    = 8,
    parameter int LW    = lane_w(LANES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [LANES-1:0][DW-1:0]  in_r,
    input  logic [LANES-1:0][TW-1:0]  in_theta,
    output logic [DW-1:0]             out_r,
    output logic [TW-1:0]             out_theta,
    output logic [LW-1:0]             out_lane
);

    logic [DW-1:0] best_r;
    logic [TW-1:0] best_t;
    logic [LW-1:0] best_l;

    // Strict '>' keeps the earliest lane on equal magnitudes.
    always_comb begin
        best_r = in_r[0];
        best_t = in_theta[0];
        best_l = '0;
        for (int i = 1; i < LANES; i++) begin
            if (in_r[i] > best_r) begin
                best_r = in_r[i];
                best_t = in_theta[i];
                best_l = LW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r     <= '0;
            out_theta <= '0;
            out_lane  <= '0;
        end else if (en) begin
            out_r     <= best_r;
            out_theta <= best_t;
            out_lane  <= best_l;
        end
    end

endmodule

// File: rtl/cfr_pd_mp.sv
// Multi-lane CFR peak detector: local maxima over group maxima, with blanking.
module cfr_pd_mp
    import cfr_pkg::*;
#(
    parameter int ITERATIONS = 7,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int LANE_W    = lane_w(LANES)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [LANES-1:0][DATA_WIDTH:0]      data_r,
    input  logic [LANES-1:0][ITERATIONS:0]      data_theta,
    input  logic                                data_valid,
    input  logic                                ctrl_enable,
    input  logic [DATA_WIDTH:0]                 ctrl_pd_threshold,
    input  logic [DATA_WIDTH:0]                 ctrl_clipping_threshold,
    input  logic [7:0]                          ctrl_min_spacing,
    output logic [DATA_WIDTH:0]                 peak_r,
    output logic [ITERATIONS:0]                 peak_theta,
    output logic [LANE_W-1:0]                   peak_lane,
    output logic [DATA_WIDTH:0]                 peak_excess,
    output logic                                peak_valid,
    output logic [CNT_WIDTH-1:0]                stat_peak_count,
    output logic [CNT_WIDTH-1:0]                stat_drop_count
);

    // nx = m[n+1] (tree output), cu = m[n] under test, pv_r = m[n-1]
    logic [DATA_WIDTH:0]  nx_r, cu_r, pv_r;
    logic [ITERATIONS:0]  nx_t, cu_t;
    logic [LANE_W-1:0]    nx_l, cu_l;

    cfr_pd_max_tree #(
        .LANES (LANES),
        .DW    (DATA_WIDTH + 1),
        .TW    (ITERATIONS + 1),
        .LW    (LANE_W)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (data_valid),
        .in_r      (data_r),
        .in_theta  (data_theta),
        .out_r     (nx_r),
        .out_theta (nx_t),
        .out_lane  (nx_l)
    );

    pd_state_t           state, state_n;
    logic [7:0]          cnt, cnt_n;
    logic                rise, fall, cand, last, report, drop;
    logic [DATA_WIDTH:0] excess;

    assign rise   = (cu_r >= pv_r);
    assign fall   = (nx_r < cu_r);
    assign cand   = rise && fall && (cu_r >= ctrl_pd_threshold);
    // The group on which the blank counter hits zero is already open again.
    assign last   = (cnt <= 8'd1);
    assign report = cand && ((state != S_BLANK) || last);
    assign drop   = cand && (state == S_BLANK) && !last;
    assign excess = (cu_r > ctrl_clipping_threshold) ? (cu_r - ctrl_clipping_threshold) : '0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == S_BLANK && cnt != 8'd0)
            cnt_n = cnt - 8'd1;
        if (report) begin
            state_n = (ctrl_min_spacing != 8'd0) ? S_BLANK : S_IDLE;
            cnt_n   = ctrl_min_spacing;
        end else if (state == S_BLANK) begin
            if (last)
                state_n = S_IDLE;
        end else if (fall) begin
            state_n = S_IDLE;
        end else if (rise) begin
            state_n = S_RISE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cu_r            <= '0;
            cu_t            <= '0;
            cu_l            <= '0;
            pv_r            <= '0;
            state           <= S_IDLE;
            cnt             <= '0;
            peak_valid      <= 1'b0;
            peak_r          <= '0;
            peak_theta      <= '0;
            peak_lane       <= '0;
            peak_excess     <= '0;
            stat_peak_count <= '0;
            stat_drop_count <= '0;
        end else begin
            peak_valid  <= 1'b0;
            peak_r      <= '0;
            peak_theta  <= '0;
            peak_lane   <= '0;
            peak_excess <= '0;
            if (data_valid) begin
                cu_r <= nx_r;
                cu_t <= nx_t;
                cu_l <= nx_l;
                pv_r <= cu_r;
            end
            if (!ctrl_enable) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else if (data_valid) begin
                state <= state_n;
                cnt   <= cnt_n;
                if (report) begin
                    peak_valid  <= 1'b1;
                    peak_r      <= cu_r;
                    peak_theta  <= cu_t;
                    peak_lane   <= cu_l;
                    peak_excess <= excess;
                    if (stat_peak_count != '1)
                        stat_peak_count <= stat_peak_count + CNT_WIDTH'(1);
                end
                if (drop && stat_drop_count != '1)
                    stat_drop_count <= stat_drop_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cfr_pd_mp.sv
// Directed bench for cfr_pd_mp: timing, tie-break, excess, blanking, bubbles, reset, saturation.
module tb_cfr_pd_mp;

    localparam int DW = 16;
    localparam int IT = 7;
    localparam int LN = 2;
    localparam int CW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [LN-1:0][DW:0]    data_r = '0;
    logic [LN-1:0][IT:0]    data_theta = '0;
    logic                   data_valid = 1'b0;
    logic                   ctrl_enable = 1'b1;
    logic [DW:0]            ctrl_pd_threshold = 17'd100;
    logic [DW:0]            ctrl_clipping_threshold = 17'd250;
    logic [7:0]             ctrl_min_spacing = 8'd0;
    logic [DW:0]            peak_r;
    logic [IT:0]            peak_theta;
    logic [0:0]             peak_lane;
    logic [DW:0]            peak_excess;
    logic                   peak_valid;
    logic [CW-1:0]          stat_peak_count, stat_drop_count;

    cfr_pd_mp #(.ITERATIONS(IT), .DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .data_r                  (data_r),
        .data_theta              (data_theta),
        .data_valid              (data_valid),
        .ctrl_enable             (ctrl_enable),
        .ctrl_pd_threshold       (ctrl_pd_threshold),
        .ctrl_clipping_threshold (ctrl_clipping_threshold),
        .ctrl_min_spacing        (ctrl_min_spacing),
        .peak_r                  (peak_r),
        .peak_theta              (peak_theta),
        .peak_lane               (peak_lane),
        .peak_excess             (peak_excess),
        .peak_valid              (peak_valid),
        .stat_peak_count         (stat_peak_count),
        .stat_drop_count         (stat_drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int r; int t; int l; int x;} pk_t;
    pk_t pq[$];
    int  zviol = 0;

    always @(negedge clk) begin
        if (peak_valid)
            pq.push_back('{cyc, int'(peak_r), int'(peak_theta), int'(peak_lane), int'(peak_excess)});
        else if (peak_r != '0 || peak_theta != '0 || peak_lane != '0 || peak_excess != '0)
            zviol <= zviol + 1;
    end

    int total = 0;
    int bad   = 0;
    int last_k = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_pk(input string tag, input int idx, input int c, input int r,
                          input int t, input int l, input int x);
        if (idx < pq.size()) begin
            chk({tag, "_cyc"},    pq[idx].c, c);
            chk({tag, "_r"},      pq[idx].r, r);
            chk({tag, "_theta"},  pq[idx].t, t);
            chk({tag, "_lane"},   pq[idx].l, l);
            chk({tag, "_excess"}, pq[idx].x, x);
        end else begin
            chk({tag, "_missing"}, pq.size(), idx + 1);
        end
    endtask

    task automatic grp(input int a, input int b, input int ta = 0, input int tb = 0, input bit v = 1'b1);
        @(negedge clk);
        data_r[0]     = 17'(a);
        data_r[1]     = 17'(b);
        data_theta[0] = 8'(ta);
        data_theta[1] = 8'(tb);
        data_valid    = v;
        last_k        = cyc;
    endtask

    task automatic flush();
        repeat (3) grp(10, 10);
        repeat (3) grp(0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_r     = '0;
        data_theta = '0;
        @(negedge clk);
        rst_n = 1'b1;
        pq.delete();
    endtask

    int k2, k7;

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_valid", peak_valid, 0);
        chk("rst_r", peak_r, 0);
        chk("rst_peak_cnt", stat_peak_count, 0);
        chk("rst_drop_cnt", stat_drop_count, 0);
        do_reset();

        // basic peak, lane 1, below clip
        grp(50, 30); grp(120, 100); grp(150, 200, 11, 22); k2 = last_k;
        grp(150, 140); flush();
        chk("t1_n", pq.size(), 1);
        chk_pk("t1", 0, k2 + 3, 200, 22, 1, 0);
        chk("t1_peak_cnt", stat_peak_count, 1);
        chk("t1_drop_cnt", stat_drop_count, 0);

        // tie resolves to lane 0, excess 300-250
        do_reset();
        grp(100, 100); grp(300, 300, 5, 6); k2 = last_k; grp(100, 100); flush();
        chk("t2_n", pq.size(), 1);
        chk_pk("t2", 0, k2 + 3, 300, 5, 0, 50);

        // excess 400-250
        do_reset();
        grp(100, 90); grp(399, 400, 7, 9); k2 = last_k; grp(100, 100); flush();
        chk("t3_n", pq.size(), 1);
        chk_pk("t3", 0, k2 + 3, 400, 9, 1, 150);

        // blanking with min_spacing 4
        do_reset();
        ctrl_min_spacing = 8'd4;
        grp(10, 0); grp(150, 0); grp(0, 300, 0, 33); k2 = last_k;
        grp(100, 0); grp(150, 0); grp(300, 0, 44, 0); grp(100, 0);
        grp(0, 300, 0, 55); k7 = last_k; grp(100, 0); flush();
        chk("t4_n", pq.size(), 2);
        chk_pk("t4a", 0, k2 + 3, 300, 33, 1, 50);
        chk_pk("t4b", 1, k7 + 3, 300, 55, 1, 50);
        chk("t4_peak_cnt", stat_peak_count, 2);
        chk("t4_drop_cnt", stat_drop_count, 1);
        ctrl_min_spacing = 8'd0;

        // bubbles between every group
        do_reset();
        grp(50, 30); grp(999, 999, 1, 1, 1'b0);
        grp(120, 100); grp(999, 999, 1, 1, 1'b0);
        grp(150, 200, 11, 22); grp(999, 999, 1, 1, 1'b0);
        grp(150, 140); grp(999, 999, 1, 1, 1'b0);
        grp(10, 10); k2 = last_k; grp(999, 999, 1, 1, 1'b0);
        flush();
        chk("t5_n", pq.size(), 1);
        chk_pk("t5", 0, k2 + 1, 200, 22, 1, 0);

        // reset pulse right after the peak group
        do_reset();
        grp(50, 30); grp(120, 100); grp(150, 200, 11, 22);
        @(negedge clk);
        rst_n = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        grp(50, 40); grp(40, 30); grp(30, 20); flush();
        chk("t6_n", pq.size(), 0);
        chk("t6_peak_cnt", stat_peak_count, 0);

        // disabled: no peaks, counters hold
        do_reset();
        ctrl_enable = 1'b0;
        grp(50, 30); grp(120, 100); grp(150, 200, 11, 22); grp(150, 140); flush();
        chk("t7_n", pq.size(), 0);
        chk("t7_peak_cnt", stat_peak_count, 0);
        ctrl_enable = 1'b1;

        // counter saturation
        do_reset();
        repeat (5) begin grp(0, 0); grp(200, 0); end
        grp(0, 0); flush();
        chk("t8_n", pq.size(), 5);
        chk("t8_peak_cnt_sat", stat_peak_count, 3);
        chk("t8_drop_cnt", stat_drop_count, 0);

        chk("idle_zero", zviol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfr_pd_mp.md
CFR_PD_MP -- requirements
Module: cfr_pd_mp

Interface
REQ-001 Parameter ITERATIONS, default 7, SHALL set theta width to ITERATIONS+1 bits.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set magnitude width to DATA_WIDTH+1 bits, unsigned.
REQ-003 Parameter LANES, default 2, legal 1/2/4/8, SHALL set parallel samples per clock; LANE_W = max(1, clog2(LANES)).
REQ-004 Parameter CNT_WIDTH, default 16, SHALL set status counter width.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 data_r  in  LANES x (DATA_WIDTH+1)  per-lane magnitude; lane 0 is earliest in time.
REQ-008 data_theta  in  LANES x (ITERATIONS+1)  per-lane phase angle.
REQ-009 data_valid  in  1  qualifies data_r/data_theta as one sample group.
REQ-010 peak_r, peak_theta  out  DATA_WIDTH+1, ITERATIONS+1  magnitude/angle of reported peak.
REQ-011 peak_lane  out  LANE_W  lane index of reported peak.
REQ-012 peak_excess  out  DATA_WIDTH+1  peak_r minus ctrl_clipping_threshold, floored at 0.
REQ-013 peak_valid  out  1  one-cycle pulse qualifying peak outputs.
REQ-014 ctrl_enable  in  1; ctrl_pd_threshold, ctrl_clipping_threshold  in  DATA_WIDTH+1; ctrl_min_spacing  in  8  blanking length in groups.
REQ-015 stat_peak_count, stat_drop_count  out  CNT_WIDTH  saturating counts of reported and blanked peaks.

Function
REQ-016 Per valid group n, m[n] SHALL be the lane maximum of data_r; ties resolve to the lowest lane; its theta and lane index travel with it.
REQ-017 Pipeline stages SHALL advance only on data_valid=1; invalid cycles are bubbles and do not alter history.
REQ-018 Group n SHALL be a candidate when m[n] >= m[n-1], m[n+1] < m[n], and m[n] >= ctrl_pd_threshold; a plateau reports its last group.
REQ-019 With continuous data_valid, peak_valid for group n SHALL assert exactly 3 cycles after group n is presented; generally, one cycle after the valid cycle carrying group n+2.
REQ-020 FSM states SHALL be S_IDLE, S_RISE, S_BLANK: S_IDLE->S_RISE on m[n]>=m[n-1]; S_RISE->S_IDLE on fall without threshold; S_RISE->S_BLANK on a reported candidate with ctrl_min_spacing>0, else S_IDLE; S_BLANK->S_IDLE when the blank counter reaches 0.
REQ-021 On entering S_BLANK, the counter SHALL load ctrl_min_spacing and decrement once per valid group.
REQ-022 Candidates arising in S_BLANK SHALL be dropped (no peak_valid) and increment stat_drop_count; a candidate on the group the counter reaches 0 SHALL be reported.
REQ-023 peak_excess SHALL be computed at full width with no wrap; peak_r <= ctrl_clipping_threshold gives 0.
REQ-024 When peak_valid=0, peak_r, peak_theta, peak_lane, peak_excess SHALL be 0.
REQ-025 Counters SHALL saturate at all-ones and never wrap.
REQ-026 ctrl_enable=0 SHALL force peak_valid=0, FSM to S_IDLE, blank counter to 0; counters hold; history registers keep updating.
REQ-027 Control inputs SHALL be sampled each cycle; changes take effect on the next valid group.

Reset
REQ-028 On rst_n=0 all registers SHALL clear asynchronously: outputs 0, history m to 0, FSM S_IDLE, counters 0.
REQ-029 Reset mid-peak SHALL discard the pending candidate; no peak_valid for groups presented before deassertion.
REQ-030 Reset deassertion SHALL be synchronised externally; the block takes no further action.

Structure
REQ-031 Package cfr_pkg SHALL hold the FSM state enum and the LANE_W width function.
REQ-032 Lane reduction SHALL be sub-module cfr_pd_max_tree (value, theta, index; lowest-index tie-break), registered output.

Verification
REQ-033 LANES=2, threshold 100, groups max 50,120,200,150 continuous -> one peak_valid 3 cycles after group 200, peak_r=200, correct lane/theta.
REQ-034 Tie: lanes (300,300), neighbours 100 -> peak_lane=0.
REQ-035 min_spacing=4, peaks at groups 2 and 5 -> first reported, second dropped, stat_drop_count=1; peak at group 7 reported.
REQ-036 clipping_threshold 250, peak 200 -> peak_excess=0; peak 400 -> 150.
REQ-037 data_valid toggling 1010 through a peak -> same single peak_r as continuous; rst_n pulse between groups n and n+1 -> no peak.
